// File: rtl/follower_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : follower_pkg
//  Description : Shared definitions for the barcode station-ID decoder:
//                decoder FSM state encoding, data-bit count and the frame
//                acceptance rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package follower_pkg;

   // Decoder FSM states, explicit 2-bit encoding.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,   // waiting for the start-bit falling edge
      START     = 2'd1,   // measuring the start-bit low time
      WAIT_FALL = 2'd2,   // waiting for the falling edge that opens a bit cell
      WAIT_SAMP = 2'd3    // counting towards the sample point of a bit cell
   } bc_state_t;

   // Number of data bits in one frame.
   localparam int unsigned NUM_DATA_BITS = 8;

   // bit_cnt value held while the final data bit is being sampled.
   localparam logic [3:0]  LAST_BIT_IDX  = 4'(NUM_DATA_BITS - 1);

   // A received byte is a station ID only when its two MSBs are zero.
   function automatic logic id_is_valid(input logic [7:0] id);
      return (id[7:6] == 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fall_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fall_det
//  Description : Two-flop synchronizer for an asynchronous, idle-high serial
//                line, plus falling-edge detection on the synchronized value.
//  Ports       : clk   - system clock
//                rst_n - asynchronous active-low reset (flops reset to 1)
//                d     - asynchronous input line
//                q     - synchronized line (two clocks of latency)
//                fall  - high for one cycle when q has just gone 1 -> 0
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fall_det (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic fall
);

   logic r_meta;   // first stage, may go metastable
   logic r_sync;   // second stage, safe to use
   logic r_prev;   // previous synchronized value for edge detection

   // All stages reset high so that releasing reset while the line idles
   // high cannot produce a spurious falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign q    = r_sync;
   assign fall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/barcode_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : barcode_decoder
//  Description : Decodes a serial barcode frame (start bit + 8 data bits,
//                MSB first) into an 8-bit station ID. Every bit cell opens
//                with a falling edge. The start-bit low time is the reference
//                period T_ref; each data bit is sampled T_ref cycles after its
//                falling edge (high = 1, short pulse; low = 0, long pulse).
//                Frames whose two MSBs are non-zero are discarded.
//  Parameters  : TMO_W      - width of the period / timeout counter
//  Ports       : clk        - system clock
//                rst_n      - asynchronous active-low reset
//                BC         - asynchronous serial barcode line, idles high
//                clr_ID_vld - one-cycle request to clear ID_vld
//                ID         - last accepted station ID
//                ID_vld     - high while ID holds a new, valid station ID
//  Revision    : 1.0 - initial release
// ============================================================================
module barcode_decoder
   import follower_pkg::*;
#(
   parameter int TMO_W = 22
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       BC,
   input  logic       clr_ID_vld,
   output logic [7:0] ID,
   output logic       ID_vld
);

   logic             bc_s;          // synchronized barcode line
   logic             bc_fall;       // falling edge of bc_s

   bc_state_t        r_state;
   logic [TMO_W-1:0] r_count;       // cycle counter, also the timeout counter
   logic [TMO_W-1:0] r_t_ref;       // measured start-bit low time
   logic [7:0]       r_sr;          // received data bits, MSB first
   logic [3:0]       r_bit_cnt;     // data bits sampled so far
   logic             r_frame_done;  // r_sr holds a complete frame this cycle

   logic [TMO_W-1:0] w_count_inc;
   logic             w_count_sat;
   logic             w_samp_pt;

   sync_fall_det u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (BC),
      .q     (bc_s),
      .fall  (bc_fall)
   );

   assign w_count_inc = r_count + TMO_W'(1);
   assign w_count_sat = &r_count;

   // The counter is cleared on the cycle the falling edge is seen, so
   // count+1 is the number of cycles elapsed since that edge. Sampling when
   // it equals T_ref puts the sample point exactly T_ref cycles after the
   // edge. T_ref is never zero, so a wrapped count+1 can never match.
   assign w_samp_pt   = (w_count_inc == r_t_ref);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_count      <= '0;
         r_t_ref      <= '0;
         r_sr         <= 8'h00;
         r_bit_cnt    <= 4'd0;
         r_frame_done <= 1'b0;
         ID           <= 8'h00;
         ID_vld       <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;

         case (r_state)
            IDLE: begin
               if (bc_fall) begin
                  r_count   <= '0;
                  r_bit_cnt <= 4'd0;
                  r_state   <= START;
               end
            end

            START: begin
               // The edge cycle itself was low, so the low time is count+1;
               // a one-cycle start bit therefore yields T_ref = 1.
               if (w_count_sat) begin
                  r_state <= IDLE;
               end else if (!bc_s) begin
                  r_count <= w_count_inc;
               end else begin
                  r_t_ref <= w_count_inc;
                  r_state <= WAIT_FALL;
               end
            end

            WAIT_FALL: begin
               // Keeps counting so a line that never falls again times out.
               if (w_count_sat) begin
                  r_state <= IDLE;
               end else if (bc_fall) begin
                  r_count <= '0;
                  r_state <= WAIT_SAMP;
               end else begin
                  r_count <= w_count_inc;
               end
            end

            WAIT_SAMP: begin
               // The sample point takes priority over an edge in the same
               // cycle; an edge strictly before it aborts the frame.
               if (w_samp_pt) begin
                  r_sr      <= {r_sr[6:0], bc_s};
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  r_count   <= w_count_inc;
                  if (r_bit_cnt == LAST_BIT_IDX) begin
                     r_frame_done <= 1'b1;
                     r_state      <= IDLE;
                  end else begin
                     r_state      <= WAIT_FALL;
                  end
               end else if (bc_fall) begin
                  r_state <= IDLE;
               end else if (w_count_sat) begin
                  r_state <= IDLE;
               end else begin
                  r_count <= w_count_inc;
               end
            end

            default: r_state <= IDLE;
         endcase

         // r_sr stays frozen while the FSM idles, so the byte is stable on
         // the cycle after completion. A new valid ID beats a clear request.
         if (r_frame_done && id_is_valid(r_sr)) begin
            ID     <= r_sr;
            ID_vld <= 1'b1;
         end else if (clr_ID_vld) begin
            ID_vld <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_barcode_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_barcode_decoder
//  Description : Self-checking bench for barcode_decoder. Frames are built
//                with period P: start bit low P/2, data 1 low P/4 (min 1),
//                data 0 low 3P/4, every cell P cycles long. The counter is
//                narrowed to keep the timeout scenario short.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_barcode_decoder;

   localparam int TMO_W = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       BC;
   logic       clr_ID_vld;
   logic [7:0] ID;
   logic       ID_vld;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_id;

   always #5 clk = ~clk;

   barcode_decoder #(.TMO_W(TMO_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .BC         (BC),
      .clr_ID_vld (clr_ID_vld),
      .ID         (ID),
      .ID_vld     (ID_vld)
   );

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_cell(input int low, input int total);
      BC = 1'b0;
      tick(low);
      BC = 1'b1;
      tick(total - low);
   endtask

   task automatic send_frame(input logic [7:0] b, input int p, input int nbits);
      int lo;
      send_cell(p / 2, p);
      for (int i = 0; i < nbits; i++) begin
         if (b[7 - i]) lo = (p / 4 < 1) ? 1 : p / 4;
         else          lo = (3 * p) / 4;
         send_cell(lo, p);
      end
      if (nbits == 8 && b[7:6] == 2'b00) exp_q.push_back(b);
   endtask

   task automatic wait_vld(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (ID_vld === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   function automatic logic [7:0] pop_exp();
      if (exp_q.size() == 0) return 8'hxx;
      return exp_q.pop_front();
   endfunction

   task automatic clear_vld();
      clr_ID_vld = 1'b1;
      tick(1);
      clr_ID_vld = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; BC = 1'b1; clr_ID_vld = 1'b0;
      tick(3);
      n_checks++;
      if (ID !== 8'h00) $display("FAIL reset_id: got %h expected 00", ID); else n_pass++;
      n_checks++;
      if (ID_vld !== 1'b0) $display("FAIL reset_vld: got %b expected 0", ID_vld); else n_pass++;
      rst_n = 1'b1;
      tick(3);
      n_checks++;
      if (ID_vld !== 1'b0 || ID !== 8'h00)
         $display("FAIL post_reset_idle: got vld=%b id=%h expected vld=0 id=00", ID_vld, ID);
      else n_pass++;
   endtask

   task automatic test_basic();
      bit seen;
      logic [7:0] e;
      send_frame(8'h01, 64, 8);
      wait_vld(10, seen);
      e = pop_exp();
      n_checks++;
      if (!seen || ID !== e) $display("FAIL basic_01: got vld=%b id=%h expected vld=1 id=%h", seen, ID, e);
      else n_pass++;
      clear_vld();
      n_checks++;
      if (ID_vld !== 1'b0 || ID !== 8'h01)
         $display("FAIL clear_vld: got vld=%b id=%h expected vld=0 id=01", ID_vld, ID);
      else n_pass++;
      send_frame(8'h02, 64, 8);
      wait_vld(10, seen);
      e = pop_exp();
      n_checks++;
      if (!seen || ID !== e) $display("FAIL basic_02: got vld=%b id=%h expected vld=1 id=%h", seen, ID, e);
      else n_pass++;
      last_id = 8'h02;
   endtask

   task automatic test_invalid();
      bit seen;
      logic [7:0] e;
      clear_vld();
      send_frame(8'hC5, 64, 8);
      tick(10);
      n_checks++;
      if (ID_vld !== 1'b0 || ID !== last_id)
         $display("FAIL invalid_c5: got vld=%b id=%h expected vld=0 id=%h", ID_vld, ID, last_id);
      else n_pass++;
      send_frame(8'h05, 64, 8);
      wait_vld(10, seen);
      e = pop_exp();
      n_checks++;
      if (!seen || ID !== e) $display("FAIL after_invalid_05: got vld=%b id=%h expected vld=1 id=%h", seen, ID, e);
      else n_pass++;
      last_id = 8'h05;
   endtask

   task automatic test_clr_collision();
      bit seen;
      logic [7:0] seen_id;
      logic [7:0] e;
      clear_vld();
      seen = 1'b0;
      seen_id = 8'h00;
      clr_ID_vld = 1'b1;   // held through the whole frame, including completion
      fork
         send_frame(8'h15, 64, 8);
         begin
            for (int i = 0; i < 9 * 64 + 12; i++) begin
               tick(1);
               if (ID_vld === 1'b1 && !seen) begin
                  seen = 1'b1;
                  seen_id = ID;
               end
            end
         end
      join
      clr_ID_vld = 1'b0;
      e = pop_exp();
      n_checks++;
      if (!seen || seen_id !== e)
         $display("FAIL set_beats_clr: got vld_seen=%b id=%h expected vld_seen=1 id=%h", seen, seen_id, e);
      else n_pass++;
      n_checks++;
      if (ID_vld !== 1'b0) $display("FAIL held_clr_clears: got %b expected 0", ID_vld); else n_pass++;
      last_id = 8'h15;
   endtask

   task automatic test_reset_midframe();
      bit seen;
      logic [7:0] e;
      send_frame(8'h3A, 64, 4);
      rst_n = 1'b0;
      tick(2);
      n_checks++;
      if (ID !== 8'h00 || ID_vld !== 1'b0)
         $display("FAIL midframe_reset: got vld=%b id=%h expected vld=0 id=00", ID_vld, ID);
      else n_pass++;
      rst_n = 1'b1;
      tick(3);
      send_frame(8'h3A, 64, 8);
      wait_vld(10, seen);
      e = pop_exp();
      n_checks++;
      if (!seen || ID !== e) $display("FAIL after_reset_3a: got vld=%b id=%h expected vld=1 id=%h", seen, ID, e);
      else n_pass++;
      last_id = 8'h3A;
   endtask

   task automatic test_timeout();
      bit seen;
      logic [7:0] e;
      clear_vld();
      BC = 1'b0;
      tick((1 << TMO_W) + 8);
      BC = 1'b1;
      tick(6);
      n_checks++;
      if (ID_vld !== 1'b0 || ID !== last_id)
         $display("FAIL timeout_abort: got vld=%b id=%h expected vld=0 id=%h", ID_vld, ID, last_id);
      else n_pass++;
      send_frame(8'h11, 64, 8);
      wait_vld(10, seen);
      e = pop_exp();
      n_checks++;
      if (!seen || ID !== e) $display("FAIL after_timeout_11: got vld=%b id=%h expected vld=1 id=%h", seen, ID, e);
      else n_pass++;
   endtask

   task automatic test_periods();
      bit seen;
      logic [7:0] e;
      int periods[3] = '{16, 1000, 3};
      foreach (periods[k]) begin
         clear_vld();
         send_frame(8'h2A, periods[k], 8);
         wait_vld(10, seen);
         e = pop_exp();
         n_checks++;
         if (!seen || ID !== e)
            $display("FAIL period_%0d_2a: got vld=%b id=%h expected vld=1 id=%h", periods[k], seen, ID, e);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      send_frame(8'h15, 3, 8);
      send_frame(8'h33, 3, 8);
      tick(6);
      e = pop_exp();
      e = pop_exp();
      n_checks++;
      if (ID_vld !== 1'b1 || ID !== e)
         $display("FAIL back_to_back: got vld=%b id=%h expected vld=1 id=%h", ID_vld, ID, e);
      else n_pass++;
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      else n_pass++;
   endtask

   initial begin
      last_id = 8'h00;
      test_reset();
      test_basic();
      test_invalid();
      test_clr_collision();
      test_reset_midframe();
      test_timeout();
      test_periods();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/barcode_decoder.md
BARCODE_DECODER -- requirements
Module: barcode_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port BC, input, 1 bit: serial barcode line, asynchronous to clk, idles high.
REQ-004 SHALL have port clr_ID_vld, input, 1 bit: one-cycle request to clear ID_vld.
REQ-005 SHALL have port ID, output, 8 bits: last station ID received.
REQ-006 SHALL have port ID_vld, output, 1 bit: high while ID holds a new, valid station ID.
REQ-007 SHALL have parameter TMO_W, default 22, meaning the width of the period counter, matching the transmitter's 22-bit period field.

Function
REQ-008 SHALL pass BC through a two-flop synchronizer, and all decoding SHALL use the synchronized value BC_s, adding 2 cycles of input latency.
REQ-009 SHALL detect a falling edge as BC_s_prev=1 and BC_s=0.
REQ-010 Protocol SHALL be: a start bit followed by 8 data bits, MSB first, where each bit cell begins with a falling edge of BC.
REQ-011 The start-bit low duration in clk cycles SHALL be captured as reference period T_ref.
REQ-012 Each data bit SHALL be sampled exactly T_ref cycles after its falling edge: BC_s=1 gives 1 (short low pulse), and BC_s=0 gives 0 (long low pulse).
REQ-013 The FSM SHALL have states IDLE, START, WAIT_FALL, WAIT_SAMP.
REQ-014 In IDLE, a falling edge SHALL clear the counter and move the FSM to START.
REQ-015 In START, the counter SHALL increment while BC_s=0; on BC_s=1 the FSM SHALL latch T_ref=count and move to WAIT_FALL.
REQ-016 In WAIT_FALL, a falling edge SHALL clear the counter and move the FSM to WAIT_SAMP.
REQ-017 In WAIT_SAMP, when count==T_ref the FSM SHALL shift BC_s into shift register sr[7:0] (left shift, LSB in) and increment bit_cnt.
REQ-018 After that sample in WAIT_SAMP, the FSM SHALL go to IDLE if bit_cnt reaches 8, and to WAIT_FALL otherwise.
REQ-019 On completion of the 8th bit, if sr[7:6]==2'b00, the block SHALL load ID<=sr and set ID_vld=1 on the next clock edge.
REQ-020 If sr[7:6]!=2'b00, the frame SHALL be discarded, with ID and ID_vld unchanged.
REQ-021 ID_vld SHALL stay high until clr_ID_vld; if clr and a new valid frame complete in the same cycle, set SHALL win.
REQ-022 A falling edge arriving during the wait for a sample point (before count==T_ref) SHALL abort the frame and return the FSM to IDLE.
REQ-023 Timeout: if the counter saturates at all-ones in START, WAIT_FALL, or WAIT_SAMP, the FSM SHALL abort to IDLE and ID SHALL be unchanged.
REQ-024 T_ref=0 is impossible by construction, since START is counted from 1; a minimum T_ref of 1 SHALL be supported.
REQ-025 bit_cnt SHALL be 4 bits and SHALL be cleared on every entry to START.
REQ-026 ID SHALL only change on an accepted frame and SHALL remain stable while ID_vld=1 unless a new valid frame arrives.

Reset
REQ-027 On rst_n=0 the block SHALL asynchronously set state=IDLE, ID=8'h00, ID_vld=0, count=0, T_ref=0, sr=0, bit_cnt=0, and both synchronizer flops to 1 (idle-high).
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL wait for a fresh falling edge.

Structure
REQ-029 FSM state enumeration and the constant for the number of data bits (8) SHALL reside in shared package follower_pkg.
REQ-030 The two-flop synchronizer with edge detect SHALL be sub-module sync_fall_det (ports clk, rst_n, d, q, fall); the remainder SHALL be flat.

Verification
REQ-031 Sending 8'h01 with period 22'h1000, then 8'h02 -> ID=8'h01 with ID_vld=1 within 5 cycles of the last sample; after clr_ID_vld, ID=8'h02 with ID_vld=1.
REQ-032 Sending 8'hC5 -> ID_vld stays 0, ID unchanged; a following 8'h05 frame -> ID=8'h05.
REQ-033 Pulsing clr_ID_vld in the same cycle as a valid frame completion -> ID_vld=1.
REQ-034 Pulsing rst_n low after 4 of 8 bits, then sending 8'h3A -> ID=8'h3A, with no corruption from the partial frame.
REQ-035 Holding BC low permanently after a falling edge -> the FSM returns to IDLE after 2^22-1 cycles with ID_vld=0, and a subsequent frame with 8'h11 decodes correctly.
REQ-036 Sending 8'h2A at period 22'h10, then at 22'h40000 -> both decode as 8'h2A.
